// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one SLICE-bit carry slice per stage,
// valid/ready flow control with whole-pipe stall, and N/Z/C/V result flags.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned SW    = SLICE + 1;
    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned LAST  = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    // Per-stage state: valid, carry out, running zero flag, skewed operands, partial sum
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] zacc_q;
    logic [WIDTH-1:0]  opa_q  [STAGES];
    logic [WIDTH-1:0]  opb_q  [STAGES];
    logic [WIDTH-1:0]  part_q [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_z;
    logic [WIDTH-1:0]  src_a  [STAGES];
    logic [WIDTH-1:0]  src_b  [STAGES];
    logic [WIDTH-1:0]  src_p  [STAGES];
    logic [SLICE:0]    slice_sum [STAGES];
    logic [WIDTH-1:0]  part_d [STAGES];
    logic [STAGES-1:0] cy_d;
    logic [STAGES-1:0] zacc_d;
    logic              ovf_d;
    logic              advance;

    always_comb begin
        advance = !vld_q[LAST] || out_ready;

        // Stage 0 is fed from the ports; later stages from the previous stage registers
        src_v[0] = in_valid;
        src_c[0] = carry_in;
        src_z[0] = 1'b1;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_p[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = vld_q[k-1];
            src_c[k] = cy_q[k-1];
            src_z[k] = zacc_q[k-1];
            src_a[k] = opa_q[k-1];
            src_b[k] = opb_q[k-1];
            src_p[k] = part_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, src_a[k][k*SLICE +: SLICE]}
                         + {1'b0, src_b[k][k*SLICE +: SLICE]}
                         + SW'(src_c[k]);
            part_d[k] = src_p[k];
            part_d[k][k*SLICE +: SLICE] = slice_sum[k][SLICE-1:0];
            cy_d[k]   = slice_sum[k][SLICE];
            zacc_d[k] = src_z[k] && (slice_sum[k][SLICE-1:0] == '0);
        end

        ovf_d = (src_a[LAST][MSB] == src_b[LAST][MSB]) &&
                (part_d[LAST][MSB] != src_a[LAST][MSB]);
    end

    // Whole pipe shifts together; data registers only load behind a valid transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            cy_q   <= '0;
            zacc_q <= '0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                part_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= src_v;
            for (int k = 0; k < STAGES; k++) begin
                if (src_v[k]) begin
                    cy_q[k]   <= cy_d[k];
                    zacc_q[k] <= zacc_d[k];
                    opa_q[k]  <= src_a[k];
                    opb_q[k]  <= src_b[k];
                    part_q[k] <= part_d[k];
                end
            end
            if (src_v[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[LAST];
    assign sum       = part_q[LAST];
    assign flag_n    = part_q[LAST][MSB];
    assign flag_z    = zacc_q[LAST];
    assign flag_c    = cy_q[LAST];
    assign flag_v    = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: three instances (STAGES = 1, 4, 8) share
// one stimulus stream; each task checks latency, results, flags and flow control.
module tb_pipelined_adder;
    localparam int unsigned W  = 64;
    localparam int          ND = 3;
    localparam int          STG [ND] = '{1, 4, 8};

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          carry_in;
    logic          out_ready;
    logic [ND-1:0] in_ready;
    logic [ND-1:0] out_valid;
    logic [ND-1:0] fn;
    logic [ND-1:0] fz;
    logic [ND-1:0] fc;
    logic [ND-1:0] fv;
    logic [W-1:0]  sm [ND];

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_adder #(.WIDTH(64), .STAGES(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid[0]), .out_ready(out_ready), .sum(sm[0]),
        .flag_n(fn[0]), .flag_z(fz[0]), .flag_c(fc[0]), .flag_v(fv[0])
    );
    pipelined_adder #(.WIDTH(64), .STAGES(4)) u_s4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid[1]), .out_ready(out_ready), .sum(sm[1]),
        .flag_n(fn[1]), .flag_z(fz[1]), .flag_c(fc[1]), .flag_v(fv[1])
    );
    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_s8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .out_valid(out_valid[2]), .out_ready(out_ready), .sum(sm[2]),
        .flag_n(fn[2]), .flag_z(fz[2]), .flag_c(fc[2]), .flag_v(fv[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed result packed as {N, Z, C, V, sum}
    function automatic logic [67:0] obs(input int d);
        return {fn[d], fz[d], fc[d], fv[d], sm[d]};
    endfunction

    // Reference: plain 65-bit addition, flags from the definitions
    function automatic logic [67:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s, input logic c);
        logic [W-1:0] be;
        logic [W:0]   t;
        logic         v;
        be = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, be} + 65'(c);
        v  = (x[W-1] == be[W-1]) && (t[W-1] != x[W-1]);
        return {t[W-1], (t[W-1:0] == '0), t[W], v, t[W-1:0]};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        sub      = s;
        carry_in = c;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 64'h1234, 64'h1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (out_valid[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valid stages=%0d got=%b exp=0", STG[d], out_valid[d]);
            end
            n_checks++;
            if (obs(d) !== 68'h0) begin
                n_fail++;
                $display("FAIL reset_outputs stages=%0d got=%h exp=0", STG[d], obs(d));
            end
        end
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset stages=%0d got in_ready=%b out_valid=%b exp 1/0",
                         STG[d], in_ready[d], out_valid[d]);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic         vs [5];
        logic         vc [5];
        logic [67:0]  ve [5];
        va[0] = 64'h7FFF_FFFF_FFFF_FFFF; vb[0] = 64'd1; vs[0] = 1'b0; vc[0] = 1'b0;
        ve[0] = {4'b1001, 64'h8000_0000_0000_0000};
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd0; vs[1] = 1'b0; vc[1] = 1'b1;
        ve[1] = {4'b0110, 64'h0};
        va[2] = 64'd5; vb[2] = 64'd5; vs[2] = 1'b1; vc[2] = 1'b1;
        ve[2] = {4'b0110, 64'h0};
        va[3] = 64'd3; vb[3] = 64'd5; vs[3] = 1'b1; vc[3] = 1'b1;
        ve[3] = {4'b1000, 64'hFFFF_FFFF_FFFF_FFFE};
        va[4] = 64'hFFFF_FFFF_FFFF_FFFF; vb[4] = 64'd1; vs[4] = 1'b0; vc[4] = 1'b0;
        ve[4] = {4'b0110, 64'h0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, va[i], vb[i], vs[i], vc[i]);
            for (int s = 1; s <= 10; s++) begin
                @(negedge clk);
                in_valid = 1'b0;
                for (int d = 0; d < ND; d++) begin
                    n_checks++;
                    if (out_valid[d] !== (s == STG[d])) begin
                        n_fail++;
                        $display("FAIL directed%0d_latency stages=%0d cycle=%0d got=%b exp=%b",
                                 i, STG[d], s, out_valid[d], (s == STG[d]));
                    end
                    if (s == STG[d]) begin
                        n_checks++;
                        if (obs(d) !== ve[i]) begin
                            n_fail++;
                            $display("FAIL directed%0d_result stages=%0d got=%h exp=%h",
                                     i, STG[d], obs(d), ve[i]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        logic         ts [8];
        logic         tc [8];
        logic [67:0]  te [8];
        logic         ev;
        for (int i = 0; i < 8; i++) begin
            ta[i] = {$urandom, $urandom};
            tb[i] = {$urandom, $urandom};
            ts[i] = 1'(i % 2);
            tc[i] = 1'($urandom_range(0, 1));
            te[i] = model(ta[i], tb[i], ts[i], tc[i]);
        end
        for (int s = 0; s <= 20; s++) begin
            @(negedge clk);
            if (s >= 1) begin
                for (int d = 0; d < ND; d++) begin
                    ev = (s >= STG[d]) && (s < STG[d] + 8);
                    n_checks++;
                    if (out_valid[d] !== ev) begin
                        n_fail++;
                        $display("FAIL b2b_valid stages=%0d cycle=%0d got=%b exp=%b",
                                 STG[d], s, out_valid[d], ev);
                    end
                    if (ev) begin
                        n_checks++;
                        if (obs(d) !== te[s - STG[d]]) begin
                            n_fail++;
                            $display("FAIL b2b_result stages=%0d idx=%0d got=%h exp=%h",
                                     STG[d], s - STG[d], obs(d), te[s - STG[d]]);
                        end
                    end
                end
            end
            if (s < 8) drive(1'b1, ta[s], tb[s], ts[s], tc[s]);
            else       in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  ta [8];
        logic [W-1:0]  tb [8];
        logic          tc [8];
        logic [67:0]   te [8];
        logic [67:0]   snap [ND];
        logic [ND-1:0] snap_v;
        logic          held;
        int            idx [ND];
        for (int i = 0; i < 8; i++) begin
            ta[i] = {$urandom, $urandom};
            tb[i] = {$urandom, $urandom};
            tc[i] = 1'($urandom_range(0, 1));
            te[i] = model(ta[i], tb[i], 1'b1, tc[i]);
        end
        held   = 1'b0;
        snap_v = '0;
        for (int d = 0; d < ND; d++) idx[d] = 0;
        for (int s = 0; s <= 30; s++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (held && snap_v[d]) begin
                    n_checks++;
                    if (out_valid[d] !== 1'b1 || obs(d) !== snap[d]) begin
                        n_fail++;
                        $display("FAIL stall_hold stages=%0d cycle=%0d got=%b/%h exp=1/%h",
                                 STG[d], s, out_valid[d], obs(d), snap[d]);
                    end
                end
            end
            out_ready = !(s >= 8 && s <= 10);
            if (s < 8) drive(1'b1, ta[s], tb[s], 1'b1, tc[s]);
            else       in_valid = 1'b0;
            #1;
            for (int d = 0; d < ND; d++) begin
                if (!out_ready && out_valid[d]) begin
                    n_checks++;
                    if (in_ready[d] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_in_ready stages=%0d cycle=%0d got=%b exp=0",
                                 STG[d], s, in_ready[d]);
                    end
                end
                if (out_ready) begin
                    n_checks++;
                    if (in_ready[d] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL flow_in_ready stages=%0d cycle=%0d got=%b exp=1",
                                 STG[d], s, in_ready[d]);
                    end
                end
                if (out_valid[d] && out_ready) begin
                    n_checks++;
                    if (idx[d] >= 8) begin
                        n_fail++;
                        $display("FAIL bp_extra stages=%0d got=%0d results exp=8", STG[d], idx[d] + 1);
                    end else begin
                        if (obs(d) !== te[idx[d]]) begin
                            n_fail++;
                            $display("FAIL bp_result stages=%0d idx=%0d got=%h exp=%h",
                                     STG[d], idx[d], obs(d), te[idx[d]]);
                        end
                        idx[d]++;
                    end
                end
                snap[d]   = obs(d);
                snap_v[d] = out_valid[d];
            end
            held = !out_ready;
        end
        out_ready = 1'b1;
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (idx[d] != 8) begin
                n_fail++;
                $display("FAIL bp_count stages=%0d got=%0d exp=8", STG[d], idx[d]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int s = 0; s <= 15; s++) begin
            @(negedge clk);
            if (s == 4) begin
                for (int d = 0; d < ND; d++) begin
                    n_checks++;
                    if (out_valid[d] !== 1'b0 || obs(d) !== 68'h0) begin
                        n_fail++;
                        $display("FAIL midreset_clear stages=%0d got=%b/%h exp=0/0",
                                 STG[d], out_valid[d], obs(d));
                    end
                end
            end
            if (s == 5) begin
                for (int d = 0; d < ND; d++) begin
                    n_checks++;
                    if (in_ready[d] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL midreset_ready stages=%0d got=%b exp=1", STG[d], in_ready[d]);
                    end
                end
            end
            if (s > 4) begin
                for (int d = 0; d < ND; d++) begin
                    n_checks++;
                    if (out_valid[d] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL midreset_ghost stages=%0d cycle=%0d got=%b exp=0",
                                 STG[d], s, out_valid[d]);
                    end
                end
            end
            if (s < 3) begin
                drive(1'b1, 64'(s + 10), 64'(s + 20), 1'b0, 1'b0);
            end else if (s == 3) begin
                reset = 1'b1;
                drive(1'b1, 64'h55, 64'h66, 1'b0, 1'b1);
            end else begin
                reset = 1'b0;
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
